// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//   Idle-driven enable controller for a downstream clock-gating cell.
//   The gate closes after cfg_idle_thresh_i consecutive idle samples.
//   It reopens on a wake request, on activity, when auto-gating is disabled,
//   or in test mode. After reopening, the gate is held open for WakeLatency
//   cycles before a wake request is acknowledged.
//
// Ports
//   clk_i             free-running (ungated) clock
//   rst_i             asynchronous active-high reset; forces gate_en_o = 1
//   test_mode_i       inhibits gating (treated as cfg_en_i = 0)
//   cfg_en_i          auto-gating enable
//   cfg_idle_thresh_i consecutive idle samples before gating (0 = never)
//   busy_i            gated-domain activity
//   wake_req_i        four-phase level wake request
//   wake_ack_o        registered wake acknowledge
//   gate_en_o         registered enable to the clock-gating cell
//   gated_o           high while the clock is gated
//   gate_evt_cnt_o    saturating count of entries into the gated state
module clk_gate_ctrl #(
    parameter int unsigned IdleCntWidth = 8,
    parameter int unsigned WakeLatency  = 2,
    parameter int unsigned EvtCntWidth  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    test_mode_i,
    input  logic                    cfg_en_i,
    input  logic [IdleCntWidth-1:0] cfg_idle_thresh_i,
    input  logic                    busy_i,
    input  logic                    wake_req_i,
    output logic                    wake_ack_o,
    output logic                    gate_en_o,
    output logic                    gated_o,
    output logic [EvtCntWidth-1:0]  gate_evt_cnt_o
);

    if (WakeLatency < 1) begin : g_bad_wake_latency
        $error("clk_gate_ctrl: WakeLatency must be at least 1");
    end

    localparam int unsigned WakeCntWidth = (WakeLatency > 1) ? $clog2(WakeLatency) : 1;
    localparam logic [WakeCntWidth-1:0] LastWake = WakeCntWidth'(WakeLatency - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_IDLE_COUNT,
        ST_GATED,
        ST_WAKING
    } state_e;

    state_e                  state, next_state;
    logic [IdleCntWidth-1:0] idle_cnt, idle_cnt_next;
    logic [WakeCntWidth-1:0] wake_cnt, wake_cnt_next;
    logic                    idle;
    logic                    wake_cause;
    logic                    thresh_hit;

    always_comb begin
        next_state    = state;
        idle_cnt_next = idle_cnt;
        wake_cnt_next = wake_cnt;

        idle       = cfg_en_i & ~test_mode_i & ~busy_i & ~wake_req_i &
                     (cfg_idle_thresh_i != '0);
        wake_cause = busy_i | wake_req_i | ~cfg_en_i | test_mode_i;
        // One extra bit so idle_cnt + 1 cannot wrap; >= honours a threshold
        // lowered while counting.
        thresh_hit = ({1'b0, idle_cnt} + {{IdleCntWidth{1'b0}}, 1'b1}) >=
                     {1'b0, cfg_idle_thresh_i};

        case (state)
            ST_ACTIVE: begin
                if (idle) begin
                    if (cfg_idle_thresh_i == IdleCntWidth'(1)) begin
                        next_state = ST_GATED;
                    end else begin
                        next_state    = ST_IDLE_COUNT;
                        idle_cnt_next = IdleCntWidth'(1);
                    end
                end
            end
            ST_IDLE_COUNT: begin
                if (!idle) begin
                    next_state    = ST_ACTIVE;
                    idle_cnt_next = '0;
                end else if (thresh_hit) begin
                    next_state    = ST_GATED;
                    idle_cnt_next = '0;
                end else begin
                    idle_cnt_next = idle_cnt + IdleCntWidth'(1);
                end
            end
            ST_GATED: begin
                if (wake_cause) begin
                    next_state    = ST_WAKING;
                    wake_cnt_next = '0;
                end
            end
            ST_WAKING: begin
                if (wake_cnt == LastWake) begin
                    next_state    = ST_ACTIVE;
                    wake_cnt_next = '0;
                end else begin
                    wake_cnt_next = wake_cnt + WakeCntWidth'(1);
                end
            end
            default: begin
                next_state    = ST_ACTIVE;
                idle_cnt_next = '0;
                wake_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_ACTIVE;
            idle_cnt       <= '0;
            wake_cnt       <= '0;
            gate_en_o      <= 1'b1;
            gated_o        <= 1'b0;
            wake_ack_o     <= 1'b0;
            gate_evt_cnt_o <= '0;
        end else begin
            state      <= next_state;
            idle_cnt   <= idle_cnt_next;
            wake_cnt   <= wake_cnt_next;
            gate_en_o  <= (next_state != ST_GATED);
            gated_o    <= (next_state == ST_GATED);
            wake_ack_o <= (next_state == ST_ACTIVE) & wake_req_i;
            if ((next_state == ST_GATED) && (state != ST_GATED) &&
                (gate_evt_cnt_o != '1)) begin
                gate_evt_cnt_o <= gate_evt_cnt_o + EvtCntWidth'(1);
            end
        end
    end

endmodule
